// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode constants, default width and divider FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [4:0] OP_DIV  = 5'b01100;
    localparam logic [4:0] OP_DIVU = 5'b01101;
    localparam logic [4:0] OP_REM  = 5'b01110;
    localparam logic [4:0] OP_REMU = 5'b01111;

    // ctrl[4:2] shared by every divide-class opcode
    localparam logic [2:0] OP_DIV_CLASS = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational radix-2 restoring division iteration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] dvs_in,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    // Shift the next dividend bit in from the top of the quotient register;
    // the low end of that register fills with quotient bits as it empties.
    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        trial   = shifted - {2'b00, dvs_in};
        if (!trial[XLEN+1]) begin
            rem_out = trial[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end else begin
            rem_out = shifted[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
// Module      : seq_divider
// Description : Handshaked multi-cycle div/divu/rem/remu unit (restoring).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider
    import alu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      ctrl,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] y
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   y_q, y_d;
    logic              rem_op_q, rem_op_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     step_rem;
    logic [XLEN-1:0]   step_quo;
    logic [XLEN-1:0]   fin_quo, fin_rem;

    div_step #(
        .XLEN (XLEN)
    ) u_div_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .dvs_in  (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign y         = y_q;

    always_comb begin
        a_neg   = ~ctrl[0] & a[XLEN-1];
        b_neg   = ~ctrl[0] & b[XLEN-1];
        a_mag   = a_neg ? (~a + 1'b1) : a;
        b_mag   = b_neg ? (~b + 1'b1) : b;
        fin_quo = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
        fin_rem = neg_rem_q ? (~step_rem[XLEN-1:0] + 1'b1) : step_rem[XLEN-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        y_d       = y_q;
        rem_op_d  = rem_op_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    rem_op_d  = ctrl[1];
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    if (ctrl[4:2] != OP_DIV_CLASS) begin
                        y_d     = '0;
                        state_d = DONE;
                    end else if (b == '0) begin
                        y_d     = ctrl[1] ? a : '1;
                        state_d = DONE;
                    end else if (!ctrl[0] && (a == INT_MIN) && (b == '1)) begin
                        y_d     = ctrl[1] ? '0 : INT_MIN;
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_mag;
                        dvs_d   = b_mag;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                // Final iteration: sign-correct the step output directly so
                // the result is ready in the same edge that enters DONE.
                if (cnt_q == LAST_ITER) begin
                    cnt_d   = '0;
                    y_d     = rem_op_q ? fin_rem : fin_quo;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            y_q       <= '0;
            rem_op_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            y_q       <= y_d;
            rem_op_q  <= rem_op_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
// ============================================================================
// Module      : tb_seq_divider
// Description : Directed self-checking bench for seq_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_divider;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      ctrl;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] y;

    int n_tests;
    int n_fail;

    seq_divider #(
        .XLEN  (XLEN),
        .CNT_W (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present one request, scramble the operands right after acceptance,
    // wait for the result and check value and latency (edges after accept).
    task automatic run_op(input string tag, input logic [4:0] op,
                          input logic [31:0] opa, input logic [31:0] opb,
                          input logic [31:0] exp_y, input int exp_lat,
                          input int hold);
        int cyc;
        logic [31:0] y_seen;
        @(negedge clk);
        check({tag, "/in_ready"}, {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        a        = opa;
        b        = opb;
        ctrl     = op;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = ~opa;
        b        = opb + 32'd3;
        ctrl     = 5'b00000;
        cyc      = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "/lat"}, cyc, exp_lat);
        check({tag, "/y"}, y, exp_y);
        if (hold > 0) begin
            y_seen = y;
            repeat (hold) @(posedge clk);
            #1;
            check({tag, "/hold_y"}, y, y_seen);
            check({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "/hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        if (hold > 0) begin
            check({tag, "/release_valid"}, {31'd0, out_valid}, 32'd0);
            check({tag, "/release_in_ready"}, {31'd0, in_ready}, 32'd1);
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        ctrl      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/in_ready", {31'd0, in_ready}, 32'd0);
        check("reset/out_valid", {31'd0, out_valid}, 32'd0);
        check("reset/y", y, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset/in_ready", {31'd0, in_ready}, 32'd1);

        run_op("div_pos",   OP_DIV,  32'd10000, 32'd8, 32'd1250, 32, 0);
        run_op("rem_pos",   OP_REM,  32'd10000, 32'd8, 32'd0,    32, 0);
        run_op("divu_pos",  OP_DIVU, 32'd10000, 32'd8, 32'd1250, 32, 0);
        run_op("remu_pos",  OP_REMU, 32'd10000, 32'd8, 32'd0,    32, 0);

        run_op("div_neg",   OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 0);
        run_op("rem_neg",   OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 0);
        run_op("divu_neg",  OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32, 0);
        run_op("remu_neg",  OP_REMU, 32'hFFFF_FFF9, 32'd2, 32'd1,        32, 0);
        run_op("div_negb",  OP_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32, 0);
        run_op("rem_negb",  OP_REM,  32'd100, 32'hFFFF_FFF9, 32'd2,        32, 0);
        run_op("rem_nega",  OP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32, 0);

        run_op("div_by0",   OP_DIV,  32'd10000, 32'd0, 32'hFFFF_FFFF, 0, 0);
        run_op("divu_by0",  OP_DIVU, 32'd10000, 32'd0, 32'hFFFF_FFFF, 0, 0);
        run_op("rem_by0",   OP_REM,  32'd10000, 32'd0, 32'd10000,     0, 0);
        run_op("remu_by0",  OP_REMU, 32'd10000, 32'd0, 32'd10000,     0, 0);

        run_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
        run_op("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         0, 0);
        run_op("divu_big",  OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32, 0);
        run_op("bad_op",    5'b00000, 32'd5, 32'd3, 32'd0, 0, 0);

        run_op("backpress", OP_DIVU, 32'd1000, 32'd7, 32'd142, 32, 10);

        // Abort a divide partway through CALC with a synchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'd10000;
        b        = 32'd8;
        ctrl     = OP_DIV;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort/out_valid", {31'd0, out_valid}, 32'd0);
        check("abort/y", y, 32'd0);
        check("abort/in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("abort/no_result", {31'd0, out_valid}, 32'd0);
        run_op("after_abort", OP_DIV, 32'd10000, 32'd8, 32'd1250, 32, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
